// File: rtl/l2_port_arbiter.sv
// Round-robin arbiter and sequencer for the single-ported L2 array: serialises
// NCORES L1 read/write requests onto one cache port, one transaction in flight.
module l2_port_arbiter #(
  parameter int NCORES     = 8,
  parameter int AW         = 13,
  parameter int DW         = 64,
  parameter int RD_LATENCY = 1
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic [NCORES-1:0]    req_valid,
  input  logic [NCORES-1:0]    req_write,
  input  logic [NCORES*AW-1:0] req_addr,
  input  logic [NCORES*DW-1:0] req_wdata,
  output logic [NCORES-1:0]    req_ready,
  output logic [NCORES-1:0]    resp_valid,
  output logic [DW-1:0]        resp_data,
  output logic [AW-1:0]        cache_addr,
  output logic [DW-1:0]        cache_wdata,
  output logic                 cache_read,
  output logic                 cache_write,
  input  logic [DW-1:0]        cache_rdata
);

  localparam int PW = (NCORES > 1) ? $clog2(NCORES) : 1;
  localparam int CW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam logic [NCORES-1:0] ONE_OH = {{(NCORES-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]     id_q, id_d;
  logic              wr_q, wr_d;

  logic [AW-1:0]     cache_addr_q, cache_addr_d;
  logic [DW-1:0]     cache_wdata_q, cache_wdata_d;
  logic              cache_read_q, cache_read_d;
  logic              cache_write_q, cache_write_d;
  logic [NCORES-1:0] resp_valid_q, resp_valid_d;
  logic [DW-1:0]     resp_data_q, resp_data_d;

  logic [PW-1:0]     win_s;
  logic              found_s;
  logic              accept_s;
  logic [NCORES-1:0] win_oh_s;

  // Round-robin search: first valid core starting at rr_ptr, wrapping mod NCORES.
  always_comb begin
    int            sum;
    logic [PW-1:0] idx;
    found_s = 1'b0;
    win_s   = '0;
    sum     = 0;
    idx     = '0;
    for (int k = 0; k < NCORES; k++) begin
      sum = int'(rr_ptr_q) + k;
      if (sum >= NCORES) begin
        sum = sum - NCORES;
      end else begin
        sum = sum;
      end
      idx = PW'(sum);
      if (!found_s && req_valid[idx]) begin
        found_s = 1'b1;
        win_s   = idx;
      end else begin
        found_s = found_s;
      end
    end
  end

  assign win_oh_s = found_s ? (ONE_OH << win_s) : '0;
  assign accept_s = (state_q == S_IDLE) && found_s;

  // State register plus the per-transaction control latched on accept.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      rr_ptr_q <= '0;
      id_q     <= '0;
      wr_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rr_ptr_q <= rr_ptr_d;
      id_q     <= id_d;
      wr_q     <= wr_d;
    end
  end

  // Next-state logic; read wait length is counted down from RD_LATENCY-1.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (found_s) begin
          state_d = S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (wr_q) begin
          state_d = S_RESP;
        end else if (RD_LATENCY == 1) begin
          state_d = S_RESP;
        end else begin
          state_d = S_WAIT;
          cnt_d   = CW'(RD_LATENCY - 1);
        end
      end
      S_WAIT: begin
        if (cnt_q == CW'(1)) begin
          state_d = S_RESP;
          cnt_d   = '0;
        end else begin
          state_d = S_WAIT;
          cnt_d   = cnt_q - CW'(1);
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output logic: combinational grant, next values of the registered port outputs.
  always_comb begin
    req_ready     = '0;
    rr_ptr_d      = rr_ptr_q;
    id_d          = id_q;
    wr_d          = wr_q;
    cache_addr_d  = cache_addr_q;
    cache_wdata_d = cache_wdata_q;
    cache_read_d  = 1'b0;
    cache_write_d = 1'b0;
    resp_valid_d  = '0;
    resp_data_d   = resp_data_q;

    if ((state_q == S_IDLE) && resetn) begin
      req_ready = win_oh_s;
    end else begin
      req_ready = '0;
    end

    if (accept_s) begin
      id_d          = win_s;
      wr_d          = req_write[win_s];
      cache_addr_d  = req_addr[win_s*AW +: AW];
      cache_wdata_d = req_wdata[win_s*DW +: DW];
      cache_write_d = req_write[win_s];
      cache_read_d  = ~req_write[win_s];
      if (win_s == PW'(NCORES - 1)) begin
        rr_ptr_d = '0;
      end else begin
        rr_ptr_d = win_s + PW'(1);
      end
    end else begin
      rr_ptr_d = rr_ptr_q;
    end

    // Read data is sampled on the very edge that enters RESP.
    if (state_d == S_RESP) begin
      resp_valid_d = ONE_OH << id_q;
      if (wr_q) begin
        resp_data_d = '0;
      end else begin
        resp_data_d = cache_rdata;
      end
    end else begin
      resp_valid_d = '0;
    end
  end

  // Registered cache-port and response outputs.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cache_addr_q  <= '0;
      cache_wdata_q <= '0;
      cache_read_q  <= 1'b0;
      cache_write_q <= 1'b0;
      resp_valid_q  <= '0;
      resp_data_q   <= '0;
    end else begin
      cache_addr_q  <= cache_addr_d;
      cache_wdata_q <= cache_wdata_d;
      cache_read_q  <= cache_read_d;
      cache_write_q <= cache_write_d;
      resp_valid_q  <= resp_valid_d;
      resp_data_q   <= resp_data_d;
    end
  end

  assign cache_addr  = cache_addr_q;
  assign cache_wdata = cache_wdata_q;
  assign cache_read  = cache_read_q;
  assign cache_write = cache_write_q;
  assign resp_valid  = resp_valid_q;
  assign resp_data   = resp_data_q;

endmodule

// File: tb/tb_l2_port_arbiter.sv
// Bench for l2_port_arbiter: RD_LATENCY=1 instance against a transaction-level
// model with random traffic, plus directed RD_LATENCY=4 and RD_LATENCY=3 instances.
module tb_l2_port_arbiter;
  localparam int N  = 8;
  localparam int AW = 13;
  localparam int DW = 64;
  localparam int LA = 1;
  localparam logic [63:0] BAD = 64'hBAD0_BAD0_BAD0_BAD0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // instance A (RD_LATENCY=1)
  logic            resetn_a;
  logic [N-1:0]    valid_a, write_a, ready_a, rv_a;
  logic [N*AW-1:0] addr_a;
  logic [N*DW-1:0] wdata_a;
  logic [DW-1:0]   rdata_a, rd_a, cwd_a;
  logic [AW-1:0]   caddr_a;
  logic            crd_a, cwr_a;

  // instances B (RD_LATENCY=4) and C (RD_LATENCY=3) share their inputs
  logic            resetn_bc;
  logic [N-1:0]    valid_b, write_b, ready_b, rv_b, ready_c, rv_c;
  logic [N*AW-1:0] addr_b;
  logic [N*DW-1:0] wdata_b;
  logic [DW-1:0]   rdata_b, rd_b, cwd_b, rd_c, cwd_c;
  logic [AW-1:0]   caddr_b, caddr_c;
  logic            crd_b, cwr_b, crd_c, cwr_c;

  l2_port_arbiter #(.NCORES(N), .AW(AW), .DW(DW), .RD_LATENCY(LA)) u_dut_a (
    .clock(clk), .resetn(resetn_a), .req_valid(valid_a), .req_write(write_a),
    .req_addr(addr_a), .req_wdata(wdata_a), .req_ready(ready_a), .resp_valid(rv_a),
    .resp_data(rd_a), .cache_addr(caddr_a), .cache_wdata(cwd_a), .cache_read(crd_a),
    .cache_write(cwr_a), .cache_rdata(rdata_a));

  l2_port_arbiter #(.NCORES(N), .AW(AW), .DW(DW), .RD_LATENCY(4)) u_dut_b (
    .clock(clk), .resetn(resetn_bc), .req_valid(valid_b), .req_write(write_b),
    .req_addr(addr_b), .req_wdata(wdata_b), .req_ready(ready_b), .resp_valid(rv_b),
    .resp_data(rd_b), .cache_addr(caddr_b), .cache_wdata(cwd_b), .cache_read(crd_b),
    .cache_write(cwr_b), .cache_rdata(rdata_b));

  l2_port_arbiter #(.NCORES(N), .AW(AW), .DW(DW), .RD_LATENCY(3)) u_dut_c (
    .clock(clk), .resetn(resetn_bc), .req_valid(valid_b), .req_write(write_b),
    .req_addr(addr_b), .req_wdata(wdata_b), .req_ready(ready_c), .resp_valid(rv_c),
    .resp_data(rd_c), .cache_addr(caddr_c), .cache_wdata(cwd_c), .cache_read(crd_c),
    .cache_write(cwr_c), .cache_rdata(rdata_b));

  int n_chk = 0;
  int n_fail = 0;

  // L2 array seen by the DUT, and the model's own view of memory
  logic [DW-1:0] arr     [0:8191];
  logic [DW-1:0] ref_mem [0:8191];

  // transaction-level model state
  int            cyc, free_at, rr, t_issue, t_resp, t_id, acc_core, maxw;
  logic          t_wr, acc_pend;
  logic [AW-1:0] t_addr, e_addr;
  logic [DW-1:0] t_wdata, t_rdata, e_wdata, e_rdata;
  int            waits [N];

  // observations from DUT A
  int            obs_gnt[$], obs_gcyc[$], resp_cyc[$];
  logic [N-1:0]  resp_core[$];
  logic [DW-1:0] resp_dat[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic set_req(input int c, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    valid_a[c] = 1'b1;
    write_a[c] = wr;
    addr_a[c*AW +: AW] = a;
    wdata_a[c*DW +: DW] = d;
  endtask

  // grant phase: expected req_ready from the model, then book the transaction
  task automatic arb();
    logic [N-1:0] e_rdy, g;
    int w, idx;
    #1;
    e_rdy = '0;
    w = -1;
    if (cyc >= free_at) begin
      for (int k = 0; k < N; k++) begin
        idx = (rr + k) % N;
        if (w < 0 && valid_a[idx]) w = idx;
      end
    end
    if (w >= 0) e_rdy[w] = 1'b1;
    chk("req_ready", 64'(ready_a), 64'(e_rdy));
    g = ready_a & valid_a;
    for (int i = 0; i < N; i++) begin
      if (g[i]) begin
        obs_gnt.push_back(i);
        obs_gcyc.push_back(cyc);
      end
    end
    if (g != '0) begin
      for (int i = 0; i < N; i++) begin
        if (g[i]) waits[i] = 0;
        else if (valid_a[i]) begin
          waits[i]++;
          if (waits[i] > maxw) maxw = waits[i];
        end
      end
    end
    if (w >= 0) begin
      t_wr    = write_a[w];
      t_addr  = addr_a[w*AW +: AW];
      t_wdata = wdata_a[w*DW +: DW];
      t_id    = w;
      t_issue = cyc + 1;
      t_resp  = t_wr ? cyc + 2 : cyc + 1 + LA;
      t_rdata = t_wr ? 64'd0 : ref_mem[t_addr];
      if (t_wr) ref_mem[t_addr] = t_wdata;
      free_at = t_resp + 1;
      rr = (w + 1) % N;
      acc_pend = 1'b1;
      acc_core = w;
    end
  endtask

  // clock phase: advance one cycle, check registered outputs, act as the L2 array
  task automatic step();
    logic [N-1:0] e_rv;
    @(posedge clk);
    #1;
    cyc++;
    if (acc_pend) begin
      valid_a[acc_core] = 1'b0;
      acc_pend = 1'b0;
    end
    e_rv = '0;
    if (cyc == t_issue) begin
      e_addr  = t_addr;
      e_wdata = t_wdata;
    end
    if (cyc == t_resp) begin
      e_rv[t_id] = 1'b1;
      e_rdata    = t_rdata;
    end
    chk("cache_read",  64'(crd_a), 64'((cyc == t_issue) && !t_wr));
    chk("cache_write", 64'(cwr_a), 64'((cyc == t_issue) && t_wr));
    chk("cache_addr",  64'(caddr_a), 64'(e_addr));
    chk("cache_wdata", cwd_a, e_wdata);
    chk("resp_valid",  64'(rv_a), 64'(e_rv));
    chk("resp_data",   rd_a, e_rdata);
    if (rv_a != '0) begin
      resp_core.push_back(rv_a);
      resp_dat.push_back(rd_a);
      resp_cyc.push_back(cyc);
    end
    if (cwr_a) arr[caddr_a] = cwd_a;
    rdata_a = crd_a ? arr[caddr_a] : BAD;
  endtask

  task automatic cycle();
    arb();
    step();
  endtask

  task automatic drain();
    int b;
    b = 0;
    while ((valid_a != '0 || cyc < free_at) && b < 300) begin
      cycle();
      b++;
    end
    chk("drain_bound", 64'(b < 300), 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g0, r0, b;
    for (int a = 0; a < 8192; a++) begin
      arr[a]     = {32'(a) * 32'h9E37_79B1, 32'(a)};
      ref_mem[a] = {32'(a) * 32'h9E37_79B1, 32'(a)};
    end
    for (int i = 0; i < N; i++) waits[i] = 0;
    maxw = 0;
    resetn_a = 1'b0; resetn_bc = 1'b0;
    valid_a = '1; write_a = '0; addr_a = '0; wdata_a = '0; rdata_a = BAD;
    valid_b = '0; write_b = '0; addr_b = '0; wdata_b = '0; rdata_b = BAD;
    for (int i = 0; i < N; i++) begin
      addr_a[i*AW +: AW] = 13'(i + 3);
      wdata_a[i*DW +: DW] = {$urandom, $urandom};
    end

    // reset state of A, with requests present
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 64'(ready_a), 64'd0);
    chk("rst_resp_valid", 64'(rv_a), 64'd0);
    chk("rst_resp_data", rd_a, 64'd0);
    chk("rst_cache_addr", 64'(caddr_a), 64'd0);
    chk("rst_cache_wdata", cwd_a, 64'd0);
    chk("rst_cache_read", 64'(crd_a), 64'd0);
    chk("rst_cache_write", 64'(cwr_a), 64'd0);
    valid_a = '0;
    resetn_a = 1'b1;
    cyc = 0; free_at = 0; rr = 0; t_issue = -1; t_resp = -1; t_id = 0; t_wr = 1'b0;
    acc_pend = 1'b0; acc_core = 0;
    t_addr = '0; t_wdata = '0; t_rdata = '0; e_addr = '0; e_wdata = '0; e_rdata = '0;

    // round robin: all cores read continuously from reset
    g0 = obs_gnt.size();
    b = 0;
    while (obs_gnt.size() < g0 + 9 && b < 200) begin
      for (int i = 0; i < N; i++)
        if (!valid_a[i]) set_req(i, 1'b0, 13'(16 + i), {$urandom, $urandom});
      cycle();
      b++;
    end
    drain();
    for (int k = 0; k < 9; k++) chk("rr_order", 64'(obs_gnt[g0 + k]), 64'(k % N));
    for (int k = 0; k < 8; k++) chk("rr_spacing", 64'(obs_gcyc[g0 + k + 1] - obs_gcyc[g0 + k]), 64'(LA + 2));

    // single read: core2 reads 0x0A5
    arr[13'h0A5] = 64'hDEAD_BEEF_0000_0001;
    ref_mem[13'h0A5] = 64'hDEAD_BEEF_0000_0001;
    g0 = obs_gnt.size(); r0 = resp_core.size();
    set_req(2, 1'b0, 13'h0A5, {$urandom, $urandom});
    drain();
    chk("rd_grant", 64'(obs_gnt[g0]), 64'd2);
    chk("rd_resp_core", 64'(resp_core[r0]), 64'h04);
    chk("rd_resp_data", resp_dat[r0], 64'hDEAD_BEEF_0000_0001);
    chk("rd_resp_time", 64'(resp_cyc[r0] - obs_gcyc[g0]), 64'd2);

    // write then read: core5 at 0x1FFF
    g0 = obs_gnt.size(); r0 = resp_core.size();
    set_req(5, 1'b1, 13'h1FFF, 64'h1234);
    b = 0;
    while (valid_a[5] && b < 50) begin
      cycle();
      b++;
    end
    set_req(5, 1'b0, 13'h1FFF, {$urandom, $urandom});
    drain();
    chk("wr_resp_core", 64'(resp_core[r0]), 64'h20);
    chk("wr_resp_data", resp_dat[r0], 64'd0);
    chk("wr_resp_time", 64'(resp_cyc[r0] - obs_gcyc[g0]), 64'd2);
    chk("wr_to_rd_grant", 64'(obs_gcyc[g0 + 1] - obs_gcyc[g0]), 64'd3);
    chk("rd_after_wr", resp_dat[r0 + 1], 64'h1234);

    // wrap priority from rr_ptr=6
    set_req(5, 1'b0, 13'h007, {$urandom, $urandom});
    drain();
    g0 = obs_gnt.size();
    set_req(1, 1'b0, 13'h011, {$urandom, $urandom});
    set_req(7, 1'b0, 13'h017, {$urandom, $urandom});
    drain();
    chk("wrap_first", 64'(obs_gnt[g0]), 64'd7);
    chk("wrap_second", 64'(obs_gnt[g0 + 1]), 64'd1);
    set_req(0, 1'b0, 13'h020, {$urandom, $urandom});
    set_req(2, 1'b0, 13'h022, {$urandom, $urandom});
    drain();
    chk("rr_after_wrap", 64'(obs_gnt[g0 + 2]), 64'd2);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < N; i++) begin
        if (!valid_a[i] && $urandom_range(0, 3) == 0)
          set_req(i, 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 7) == 0) ? 13'h1FFF : 13'($urandom_range(0, 15)),
                  {$urandom, $urandom});
      end
      cycle();
    end
    drain();
    chk("fairness", 64'(maxw <= N - 1), 64'd1);

    // RD_LATENCY=4 read on instance B
    addr_b[3*AW +: AW] = 13'h010;
    addr_b[5*AW +: AW] = 13'h020;
    addr_b[6*AW +: AW] = 13'h033;
    wdata_b[6*DW +: DW] = 64'h5555_AAAA_0000_1111;
    @(posedge clk);
    #1;
    resetn_bc = 1'b1;
    valid_b = 8'h08;
    #1;
    chk("l4_grant", 64'(ready_b), 64'h08);
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) valid_b = 8'h20;
      rdata_b = (k == 4) ? 64'hC0FF_EE00_1234_5678 : BAD;
      #1;
      chk("l4_no_ready", 64'(ready_b), 64'd0);
      chk("l4_read", 64'(crd_b), 64'(k == 1));
      chk("l4_resp_valid", 64'(rv_b), (k == 5) ? 64'h08 : 64'd0);
    end
    chk("l4_addr", 64'(caddr_b), 64'h010);
    chk("l4_resp_data", rd_b, 64'hC0FF_EE00_1234_5678);
    @(posedge clk);
    #2;
    chk("l4_next_grant", 64'(ready_b), 64'h20);

    // reset mid-WAIT on instance C (RD_LATENCY=3)
    valid_b = '0;
    resetn_bc = 1'b0;
    #1;
    resetn_bc = 1'b1;
    valid_b = 8'h40;
    #1;
    chk("rstw_grant", 64'(ready_c), 64'h40);
    @(posedge clk);
    #1;
    valid_b = '0;
    #1;
    chk("rstw_issue", 64'(crd_c), 64'd1);
    repeat (2) @(posedge clk);
    #1;
    valid_b = 8'h82;
    resetn_bc = 1'b0;
    #1;
    chk("rstw_ready", 64'(ready_c), 64'd0);
    chk("rstw_resp_valid", 64'(rv_c), 64'd0);
    chk("rstw_resp_data", rd_c, 64'd0);
    chk("rstw_cache_addr", 64'(caddr_c), 64'd0);
    chk("rstw_cache_wdata", cwd_c, 64'd0);
    chk("rstw_cache_read", 64'(crd_c), 64'd0);
    chk("rstw_cache_write", 64'(cwr_c), 64'd0);
    @(posedge clk);
    #1;
    valid_b = '0;
    resetn_bc = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      chk("rstw_quiet_resp", 64'(rv_c), 64'd0);
      chk("rstw_quiet_strobe", 64'(crd_c | cwr_c), 64'd0);
    end
    valid_b = 8'h82;
    #1;
    chk("rstw_rr_ptr", 64'(ready_c), 64'h02);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
